// File: rtl/icache_pipe_v2.sv
// Two-stage blocking set-associative I-cache with tree-PLRU, multi-word hit fetch, index invalidate and uncached path; ICACHE_PERF_EN adds hit/miss/uncached counters.
// Latency: a hit returns data in the cycle after the request is accepted; a miss or uncached access holds cpu_busy until it completes.
// Backpressure: cpu_stall freezes stage 2, and cpu_busy blocks new requests; rd_req/ur_req stay high until rd_rdy/ur_rdy.
module icache_pipe_v2 #(
    parameter int DATA_WIDTH    = 32,
    parameter int LINE_WORD_NUM = 4,
    parameter int ASSOC_NUM     = 4,
    parameter int SET_NUM       = 128,
    parameter int FETCH_WORDS   = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cpu_req,
    input  logic [31:0]                         cpu_addr,
    input  logic                                cpu_cached,
    input  logic                                cpu_stall,
    output logic                                cpu_busy,
    output logic [DATA_WIDTH*FETCH_WORDS-1:0]   cpu_rdata,
    output logic [FETCH_WORDS-1:0]              cpu_rvalid,
    input  logic                                inv_req,
    input  logic [$clog2(SET_NUM)-1:0]          inv_index,
    output logic                                inv_ack,
    output logic                                rd_req,
    output logic [31:0]                         rd_addr,
    input  logic                                rd_rdy,
    input  logic                                ret_valid,
    input  logic [DATA_WIDTH*LINE_WORD_NUM-1:0] ret_data,
    output logic                                ur_req,
    output logic [31:0]                         ur_addr,
    input  logic                                ur_rdy,
    input  logic                                ur_ret_valid,
    input  logic [31:0]                         ur_ret_data
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]                         perf_hit_cnt,
    output logic [31:0]                         perf_miss_cnt,
    output logic [31:0]                         perf_uc_cnt
`endif
);
    localparam int OFF_W  = $clog2(LINE_WORD_NUM);
    localparam int BYTE_W = OFF_W + 2;
    localparam int IDX_W  = $clog2(SET_NUM);
    localparam int TAG_W  = 32 - IDX_W - BYTE_W;
    localparam int WAY_W  = $clog2(ASSOC_NUM);
    localparam int LINE_W = DATA_WIDTH * LINE_WORD_NUM;

    typedef enum logic [2:0] {LOOKUP, MISS, REFILL, REFILLDONE, UC_REQ, UC_WAIT, UC_DONE, INV} state_e;

    state_e                 state_q;
    logic                   s2_vld_q, s2_cached_q;
    logic [TAG_W-1:0]       s2_tag_q;
    logic [IDX_W-1:0]       s2_idx_q, inv_idx_q;
    logic [OFF_W-1:0]       s2_off_q;
    logic                   rd_req_q, ur_req_q, inv_ack_q;
    logic [31:0]            uc_data_q;
    logic [ASSOC_NUM-1:0]   valid_q [SET_NUM];
    logic [ASSOC_NUM-1:0]   plru_q  [SET_NUM];

    logic [TAG_W-1:0]       tag_ram  [ASSOC_NUM][SET_NUM];
    logic [LINE_W-1:0]      data_ram [ASSOC_NUM][SET_NUM];
    logic [TAG_W-1:0]       tag_rd_q  [ASSOC_NUM];
    logic [LINE_W-1:0]      data_rd_q [ASSOC_NUM];

    logic                   s2_load, lookup_hit, refill_we;
    logic [IDX_W-1:0]       s1_idx, rd_idx;
    logic [ASSOC_NUM-1:0]   way_hit, set_valid;
    logic [WAY_W-1:0]       hit_way, victim;
    logic [LINE_W-1:0]      hit_line;
    logic [DATA_WIDTH-1:0]  hit_words [LINE_WORD_NUM];
    logic [OFF_W:0]         lane_word;
    logic                   unused_addr_bits;

    // PLRU node n (heap order, root = 1) points toward the less recently used half.
    function automatic logic [WAY_W-1:0] plru_pick(input logic [ASSOC_NUM-1:0] b);
        logic [WAY_W:0] node;
        node = (WAY_W+1)'(1);
        for (int l = 0; l < WAY_W; l++) node = {node[WAY_W-1:0], b[node[WAY_W-1:0]]};
        return node[WAY_W-1:0];
    endfunction

    function automatic logic [ASSOC_NUM-1:0] plru_touch(input logic [ASSOC_NUM-1:0] b, input logic [WAY_W-1:0] w);
        logic [WAY_W:0]       node;
        logic [WAY_W-1:0]     w_sh;
        logic [ASSOC_NUM-1:0] nb;
        logic                 dir;
        node = (WAY_W+1)'(1);
        w_sh = w;
        nb   = b;
        for (int l = 0; l < WAY_W; l++) begin
            dir                    = w_sh[WAY_W-1];
            w_sh                   = w_sh << 1;
            nb[node[WAY_W-1:0]]    = !dir;
            node                   = {node[WAY_W-1:0], dir};
        end
        return nb;
    endfunction

    assign unused_addr_bits = ^cpu_addr[1:0];
    assign s1_idx    = cpu_addr[BYTE_W +: IDX_W];
    assign s2_load   = !cpu_stall && !cpu_busy;
    // While stage 2 holds, keep re-reading its own set so read data stays aligned with it.
    assign rd_idx    = s2_load ? s1_idx : s2_idx_q;
    assign refill_we = (state_q == REFILL) && ret_valid;
    assign set_valid = valid_q[s2_idx_q];

    always_comb begin
        way_hit  = '0;
        hit_way  = '0;
        hit_line = '0;
        for (int w = 0; w < ASSOC_NUM; w++) begin
            way_hit[w] = set_valid[w] && (tag_rd_q[w] == s2_tag_q);
            if (way_hit[w]) begin
                hit_way  = WAY_W'(w);
                hit_line = data_rd_q[w];
            end
        end
    end

    assign lookup_hit = (state_q == LOOKUP) && s2_vld_q && s2_cached_q && (|way_hit);
    assign cpu_busy   = (s2_vld_q && ((s2_cached_q && !lookup_hit) || (!s2_cached_q && state_q != UC_DONE)))
                        || (state_q == INV);

    always_comb begin
        victim = plru_pick(plru_q[s2_idx_q]);
        for (int w = ASSOC_NUM - 1; w >= 0; w--) begin
            if (!set_valid[w]) victim = WAY_W'(w);
        end
    end

    always_comb begin
        cpu_rdata  = '0;
        cpu_rvalid = '0;
        lane_word  = '0;
        for (int i = 0; i < LINE_WORD_NUM; i++) hit_words[i] = hit_line[i*DATA_WIDTH +: DATA_WIDTH];
        if (state_q == UC_DONE) begin
            cpu_rdata[DATA_WIDTH-1:0] = uc_data_q;
            cpu_rvalid[0]             = 1'b1;
        end else begin
            for (int k = 0; k < FETCH_WORDS; k++) begin
                lane_word = {1'b0, s2_off_q} + (OFF_W+1)'(k);
                if (lookup_hit && !lane_word[OFF_W]) begin
                    cpu_rvalid[k]                        = 1'b1;
                    cpu_rdata[k*DATA_WIDTH +: DATA_WIDTH] = hit_words[lane_word[OFF_W-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < ASSOC_NUM; w++) begin
            if (refill_we && victim == WAY_W'(w)) begin
                tag_ram[w][s2_idx_q]  <= s2_tag_q;
                data_ram[w][s2_idx_q] <= ret_data;
            end
            tag_rd_q[w]  <= tag_ram[w][rd_idx];
            data_rd_q[w] <= data_ram[w][rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOOKUP;
            s2_vld_q    <= 1'b0;
            s2_cached_q <= 1'b0;
            s2_tag_q    <= '0;
            s2_idx_q    <= '0;
            s2_off_q    <= '0;
            rd_req_q    <= 1'b0;
            ur_req_q    <= 1'b0;
            inv_ack_q   <= 1'b0;
            inv_idx_q   <= '0;
            uc_data_q   <= '0;
            for (int s = 0; s < SET_NUM; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (s2_load) begin
                s2_vld_q    <= cpu_req;
                s2_cached_q <= cpu_cached;
                s2_tag_q    <= cpu_addr[31 -: TAG_W];
                s2_idx_q    <= s1_idx;
                s2_off_q    <= cpu_addr[2 +: OFF_W];
            end
            if (lookup_hit) plru_q[s2_idx_q] <= plru_touch(plru_q[s2_idx_q], hit_way);
            case (state_q)
                LOOKUP: begin
                    if (inv_req) begin
                        state_q   <= INV;
                        inv_ack_q <= 1'b1;
                        inv_idx_q <= inv_index;
                    end else if (s2_vld_q && !s2_cached_q) begin
                        state_q  <= UC_REQ;
                        ur_req_q <= 1'b1;
                    end else if (s2_vld_q && !lookup_hit) begin
                        state_q  <= MISS;
                        rd_req_q <= 1'b1;
                    end
                end
                MISS: if (rd_rdy) begin
                    rd_req_q <= 1'b0;
                    state_q  <= REFILL;
                end
                REFILL: if (ret_valid) begin
                    valid_q[s2_idx_q][victim] <= 1'b1;
                    state_q                   <= REFILLDONE;
                end
                REFILLDONE: state_q <= LOOKUP;
                UC_REQ: if (ur_rdy) begin
                    ur_req_q <= 1'b0;
                    state_q  <= UC_WAIT;
                end
                UC_WAIT: if (ur_ret_valid) begin
                    uc_data_q <= ur_ret_data;
                    state_q   <= UC_DONE;
                end
                UC_DONE: if (!cpu_stall) state_q <= LOOKUP;
                INV: begin
                    valid_q[inv_idx_q] <= '0;
                    inv_ack_q          <= 1'b0;
                    state_q            <= LOOKUP;
                end
                default: state_q <= LOOKUP;
            endcase
        end
    end

    assign rd_req  = rd_req_q;
    assign ur_req  = ur_req_q;
    assign inv_ack = inv_ack_q;
    assign rd_addr = {s2_tag_q, s2_idx_q, BYTE_W'(0)};
    assign ur_addr = {s2_tag_q, s2_idx_q, s2_off_q, 2'b00};

`ifdef ICACHE_PERF_EN
    logic        s2_missed_q, miss_start, s2_done;
    logic [31:0] hit_cnt_q, miss_cnt_q, uc_cnt_q;

    assign miss_start = (state_q == LOOKUP) && !inv_req && s2_vld_q && s2_cached_q && !lookup_hit;
    assign s2_done    = s2_vld_q && !cpu_busy && !cpu_stall;

    // A refilled access completes as a hit later; s2_missed_q keeps it out of the hit count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_missed_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            uc_cnt_q    <= '0;
        end else begin
            if (s2_load)         s2_missed_q <= 1'b0;
            else if (miss_start) s2_missed_q <= 1'b1;
            if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
            if (s2_done && s2_cached_q && !s2_missed_q) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (s2_done && !s2_cached_q) uc_cnt_q <= uc_cnt_q + 32'd1;
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
    assign perf_uc_cnt   = uc_cnt_q;
`endif
endmodule

// File: tb/tb_icache_pipe_v2.sv
// Directed bench for icache_pipe_v2: vector table of hit lookups plus refill, PLRU, uncached, invalidate and reset-abort sequences.
module tb_icache_pipe_v2;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_req = 1'b0, cpu_cached = 1'b0, cpu_stall = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic         cpu_busy;
    logic [63:0]  cpu_rdata;
    logic [1:0]   cpu_rvalid;
    logic         inv_req = 1'b0;
    logic [6:0]   inv_index = '0;
    logic         inv_ack, rd_req, ur_req;
    logic [31:0]  rd_addr, ur_addr;
    logic         rd_rdy = 1'b0, ret_valid = 1'b0;
    logic [127:0] ret_data = '0;
    logic         ur_rdy = 1'b0, ur_ret_valid = 1'b0;
    logic [31:0]  ur_ret_data = '0;

    int errors = 0;
    int checks = 0;
    int ur_hs = 0;
    int ack_pulses = 0;

    icache_pipe_v2 dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_cached(cpu_cached), .cpu_stall(cpu_stall),
        .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .inv_req(inv_req), .inv_index(inv_index), .inv_ack(inv_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_data(ret_data),
        .ur_req(ur_req), .ur_addr(ur_addr), .ur_rdy(ur_rdy), .ur_ret_valid(ur_ret_valid), .ur_ret_data(ur_ret_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (ur_req && ur_rdy) ur_hs <= ur_hs + 1;
            if (inv_ack) ack_pulses <= ack_pulses + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_line(input logic [31:0] b);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = b + 32'(i);
        return l;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cpu_req = 1'b0; cpu_stall = 1'b0; inv_req = 1'b0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ur_rdy = 1'b0; ur_ret_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the bench at the negedge where the request sits in stage 2.
    task automatic issue(input logic [31:0] a, input logic c);
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = a; cpu_cached = c;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    task automatic wait_rd(input string nm, input logic [31:0] exp_addr);
        int n = 0;
        while (!rd_req && n < 20) begin @(negedge clk); n++; end
        chk({nm, "_rd_req"}, rd_req, 1);
        chk({nm, "_rd_addr"}, rd_addr, exp_addr);
    endtask

    task automatic refill(input logic [127:0] line);
        int n = 0;
        rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0; ret_valid = 1'b1; ret_data = line;
        @(negedge clk);
        ret_valid = 1'b0; ret_data = '0;
        while (cpu_busy && n < 20) begin @(negedge clk); n++; end
    endtask

    task automatic fetch_fill(input string nm, input logic [31:0] a, input logic [31:0] base);
        issue(a, 1'b1);
        chk({nm, "_miss_busy"}, cpu_busy, 1);
        wait_rd(nm, a);
        refill(mk_line(base));
        chk({nm, "_fill_busy"}, cpu_busy, 0);
        chk({nm, "_fill_data"}, cpu_rdata, {base + 32'd1, base});
        chk({nm, "_fill_vld"}, cpu_rvalid, 2'b11);
    endtask

    task automatic expect_hit(input string nm, input logic [31:0] a, input logic [31:0] base);
        issue(a, 1'b1);
        chk({nm, "_busy"}, cpu_busy, 0);
        chk({nm, "_data"}, cpu_rdata, {base + 32'd1, base});
        chk({nm, "_vld"}, cpu_rvalid, 2'b11);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [63:0] rdata;
        logic [1:0]  rvalid;
    } vec_t;

    localparam logic [31:0] A_ADDR = 32'h1FC0_0000;
    localparam logic [31:0] B_ADDR = 32'h1FC0_0800;
    localparam logic [31:0] C_ADDR = 32'h1FC0_1000;
    localparam logic [31:0] D_ADDR = 32'h1FC0_1800;
    localparam logic [31:0] E_ADDR = 32'h1FC0_2000;

    initial begin
        vec_t tbl[4];
        int   n;
        int   ack0;
        tbl[0] = '{A_ADDR + 32'h0, {32'hA1, 32'hA0}, 2'b11};
        tbl[1] = '{A_ADDR + 32'h4, {32'hA2, 32'hA1}, 2'b11};
        tbl[2] = '{A_ADDR + 32'h8, {32'hA3, 32'hA2}, 2'b11};
        tbl[3] = '{A_ADDR + 32'hC, {32'h0,  32'hA3}, 2'b01};

        do_reset();
        @(negedge clk);
        chk("rst_busy", cpu_busy, 0);
        chk("rst_rvalid", cpu_rvalid, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_ur_req", ur_req, 0);
        chk("rst_inv_ack", inv_ack, 0);

        fetch_fill("fillA", A_ADDR, 32'hA0);

        for (int i = 0; i < 4; i++) begin
            issue(tbl[i].addr, 1'b1);
            chk($sformatf("vec%0d_busy", i), cpu_busy, 0);
            chk($sformatf("vec%0d_data", i), cpu_rdata, tbl[i].rdata);
            chk($sformatf("vec%0d_vld", i), cpu_rvalid, tbl[i].rvalid);
            @(negedge clk);
            chk($sformatf("vec%0d_no_refill", i), rd_req, 0);
        end

        // Uncached access with a 3-cycle stall in the completion state.
        issue(32'hBFC0_0000, 1'b0);
        chk("uc_busy", cpu_busy, 1);
        chk("uc_early_vld", cpu_rvalid, 0);
        n = 0;
        while (!ur_req && n < 20) begin @(negedge clk); n++; end
        chk("uc_ur_req", ur_req, 1);
        chk("uc_ur_addr", ur_addr, 32'hBFC0_0000);
        ur_rdy = 1'b1;
        @(negedge clk);
        ur_rdy = 1'b0; ur_ret_valid = 1'b1; ur_ret_data = 32'h1234_5678; cpu_stall = 1'b1;
        @(negedge clk);
        ur_ret_valid = 1'b0; ur_ret_data = '0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("uc_stall%0d_data", i), cpu_rdata, {32'h0, 32'h1234_5678});
            chk($sformatf("uc_stall%0d_vld", i), cpu_rvalid, 2'b01);
            chk($sformatf("uc_stall%0d_busy", i), cpu_busy, 0);
            @(negedge clk);
        end
        cpu_stall = 1'b0;
        @(negedge clk);
        chk("uc_after_vld", cpu_rvalid, 0);
        chk("uc_one_req", ur_hs, 1);

        // The uncached address was not allocated; abandon its refill with a reset.
        issue(32'hBFC0_0000, 1'b1);
        chk("uc_noalloc_busy", cpu_busy, 1);
        wait_rd("uc_noalloc", 32'hBFC0_0000);
        rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_refill_busy", cpu_busy, 0);
        chk("rst_refill_rd_req", rd_req, 0);
        @(negedge clk);
        rst = 1'b0; ret_valid = 1'b1; ret_data = mk_line(32'h55);
        @(negedge clk);
        ret_valid = 1'b0; ret_data = '0;
        chk("late_ret_busy", cpu_busy, 0);
        chk("late_ret_vld", cpu_rvalid, 0);
        issue(32'hBFC0_0000, 1'b1);
        chk("late_ret_nowrite", cpu_busy, 1);
        wait_rd("late_ret", 32'hBFC0_0000);
        do_reset();

        // Invalidate set 0 after filling it.
        fetch_fill("fillA2", A_ADDR, 32'hA0);
        ack0 = ack_pulses;
        @(negedge clk);
        inv_req = 1'b1; inv_index = 7'd0;
        @(negedge clk);
        inv_req = 1'b0;
        chk("inv_ack_high", inv_ack, 1);
        chk("inv_busy", cpu_busy, 1);
        @(negedge clk);
        chk("inv_ack_low", inv_ack, 0);
        @(negedge clk);
        chk("inv_ack_once", ack_pulses - ack0, 1);
        fetch_fill("inv_refetch", A_ADDR, 32'hA0);

        // Fill ways 0..3 of set 0, then a fifth tag evicts the PLRU way (A).
        expect_hit("hitA", A_ADDR, 32'hA0);
        fetch_fill("fillB", B_ADDR, 32'hB0);
        fetch_fill("fillC", C_ADDR, 32'hC0);
        fetch_fill("fillD", D_ADDR, 32'hD0);
        fetch_fill("fillE", E_ADDR, 32'hE0);
        expect_hit("keepB", B_ADDR, 32'hB0);
        expect_hit("keepC", C_ADDR, 32'hC0);
        expect_hit("keepD", D_ADDR, 32'hD0);
        issue(A_ADDR, 1'b1);
        chk("evictA_busy", cpu_busy, 1);
        wait_rd("evictA", A_ADDR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
